usb_ep_array: RTL
=================

Name: usb_ep_array

Overview:
Parametrised USB endpoint controller replacing per-endpoint usb_ep instances and the top-level endpoint mux. Holds per-endpoint, per-direction double-buffer ownership, data toggle, stall, lengths and interrupt-pending state for NUM_EP endpoints. Drives handshake/toggle/bank/in_data_valid toward the usb core and generates the packet-RAM address. Exposes a 16-bit CPU control window on the io bus.

Parameters:
NUM_EP, 4, number of endpoints (1..16); endpoint numbers >= NUM_EP always STALL
EPW, 2, endpoint index width used in RAM address, clog2(NUM_EP) minimum 1
MAX_PKT, 64, max packet bytes; counter saturates at MAX_PKT

Ports:
clk_48  in  1  system clock
irst  in  1  async active-high reset
usb_rst  in  1  USB bus reset (level, synchronous)
transaction_active  in  1  token accepted, transaction in progress
endpoint  in  4  token endpoint number
direction_in  in  1  1 = IN token
setup  in  1  SETUP token
data_strobe  in  1  one byte transferred
success  in  1  one-cycle pulse, transaction completed OK
handshake  out  2  00 ack, 01 none, 10 nak, 11 stall
toggle  out  1  expected/sent DATA0/1
bank  out  1  active buffer bank
in_data_valid  out  1  IN data available
ram_addr  out  EPW+8  {ep[EPW-1:0], dir, bank, cnt[5:0]}
ram_we  out  1  OUT byte write enable
cnt  out  7  byte counter
ctrl_addr  in  EPW+2  {ep, dir, sel}
ctrl_wr_strobe  in  1  CPU write
ctrl_wr_data  in  16  CPU write data
ctrl_rd_data  out  16  CPU read data (combinational)
irq  out  1  OR of all enabled pending flags

Behaviour:
- Reset (irst) and usb_rst: all full flags, bank, toggle, stall, pending, lengths, cnt = 0; irq = 0. usb_rst keeps enable bits; irst clears them. Outputs after reset: handshake = 11 (all endpoints disabled), toggle/bank/in_data_valid/ram_we = 0.
- cnt: 0 while !transaction_active; +1 per data_strobe, saturates at MAX_PKT (bit 6 set, no wrap).
- ram_we = data_strobe && !cnt[6] && !direction_in && handshake==00.
- Selected channel = (endpoint, direction_in); SETUP uses OUT channel. Outputs combinational from selected channel state.
- handshake: ep >= NUM_EP or disabled -> 11; stall && !setup -> 11; OUT/SETUP: current bank not full -> 00 else 10; IN: current bank full -> 00 else 10. SETUP on ep0 always ACKs when enabled (ignores stall and full).
- in_data_valid = IN && current bank full.
- On success (state updates next edge): OUT: len[bank] = min(cnt, MAX_PKT), full[bank] = 1, bank flips, toggle flips, pending = 1. IN: full[bank] = 0, bank flips, toggle flips, pending = 1. SETUP: as OUT, then OUT toggle = 1, IN toggle = 1, both stalls of that endpoint cleared.
- success with handshake != 00: no state change.
- CPU sel=0 read: [0] full0 [1] full1 [2] bank [3] toggle [4] stall [5] enable [6] pending [7] iso. Write: [0]/[1] set full0/1, [2]/[3] clear full0/1, [4] set stall, [5] clear stall, [6] clear pending, [7] load toggle from [8], [9] load enable from [10], [11] load iso from [12]. Set and clear together: clear wins.
- sel=1: read/write {1'b0, len1[6:0], 1'b0, len0[6:0]}.
- Same-cycle CPU write and USB success on same channel: USB update wins for full/bank/toggle/len of affected bank; other CPU fields apply.

Optional Feature:
USB_EP_ARRAY_ISO_EN: per-channel iso bit. When set: handshake = 01 instead of 00/10; IN with no armed bank sends zero-length (in_data_valid = 0); toggle never flips; OUT with full bank overwrites it, flips bank. Without macro: iso bit reads 0, write ignored, no iso logic.

Decomposition:
- Package usb_ep_pkg: handshake encodings (HS_ACK/NONE/NAK/STALL), ctrl bit positions, sel codes, MAX_PKT.
- Sub-module usb_ep_chan: one direction's state (full[2], bank, toggle, stall, enable, pending, len[2]); instantiated 2*NUM_EP; top holds cnt, mux, decode.

Test Plan:
- irst, enable ep1 OUT, 5-byte OUT ep1 -> ACK, ram_addr ep=1,bank=0,cnt 0..4; success -> full0=1, bank=1, len0=5, toggle=1, irq=1.
- Fill both OUT banks on ep1, third OUT -> handshake 10, no ram_we; CPU clear full0 -> next OUT ACK to bank 0.
- ep0 stalled, SETUP 8 bytes -> ACK, both stalls cleared, IN and OUT toggle = 1.
- IN ep2 unarmed -> 10; CPU writes len0=3, set full0 -> IN ACK, in_data_valid=1; success -> full0=0, bank=1.
- 70-byte OUT -> cnt saturates 64, ram_we low beyond 64, len=64; endpoint 5 with NUM_EP=4 -> 11.
- Mid-transfer usb_rst -> all full/toggle/stall cleared, enable retained; ISO build: iso set -> handshake 01, toggle constant.

Source files
------------

// File: rtl/usb_ep_pkg.sv
// Shared encodings for the endpoint array: handshake codes, CPU window bit
// positions and the per-channel state record.
package usb_ep_pkg;

  localparam int MAX_PKT = 64;

  typedef enum logic [1:0] {
    HS_ACK   = 2'b00,
    HS_NONE  = 2'b01,
    HS_NAK   = 2'b10,
    HS_STALL = 2'b11
  } hs_e;

  localparam logic SEL_CTRL = 1'b0;
  localparam logic SEL_LEN  = 1'b1;

  // Read layout of the sel=0 word
  localparam int RB_FULL0   = 0;
  localparam int RB_FULL1   = 1;
  localparam int RB_BANK    = 2;
  localparam int RB_TOGGLE  = 3;
  localparam int RB_STALL   = 4;
  localparam int RB_ENABLE  = 5;
  localparam int RB_PENDING = 6;
  localparam int RB_ISO     = 7;

  // Write layout of the sel=0 word
  localparam int WB_SET_FULL0 = 0;
  localparam int WB_SET_FULL1 = 1;
  localparam int WB_CLR_FULL0 = 2;
  localparam int WB_CLR_FULL1 = 3;
  localparam int WB_SET_STALL = 4;
  localparam int WB_CLR_STALL = 5;
  localparam int WB_CLR_PEND  = 6;
  localparam int WB_LD_TOG    = 7;
  localparam int WB_TOG_VAL   = 8;
  localparam int WB_LD_EN     = 9;
  localparam int WB_EN_VAL    = 10;
  localparam int WB_LD_ISO    = 11;
  localparam int WB_ISO_VAL   = 12;

  typedef struct packed {
    logic [1:0] full;
    logic       bank;
    logic       toggle;
    logic       stall;
    logic       enable;
    logic       pending;
    logic       iso;
    logic [6:0] len0;
    logic [6:0] len1;
  } chan_st_t;

endpackage

// File: rtl/usb_ep_chan.sv
// State of one endpoint direction: double-buffer ownership, toggle, stall,
// enable, pending and lengths. Iso bit exists only with USB_EP_ARRAY_ISO_EN.
module usb_ep_chan
  import usb_ep_pkg::*;
#(
  parameter bit IS_IN = 1'b0
) (
  input  logic        clk_48,
  input  logic        irst,
  input  logic        usb_rst,
  input  logic        upd_i,
  input  logic        setup_i,
  input  logic [6:0]  len_i,
  input  logic        wr_i,
  input  logic        sel_i,
  input  logic [15:0] wr_data_i,
  output chan_st_t    st_o
);

  chan_st_t st_q, st_d;
  logic     ctrl_wr;
  logic     unused_bits;

  assign ctrl_wr = wr_i && (sel_i == SEL_CTRL);

`ifdef USB_EP_ARRAY_ISO_EN
  assign unused_bits = wr_data_i[15];
`else
  assign unused_bits = ^{wr_data_i[15], wr_data_i[12:11]};
`endif

  always_comb begin
    // NOTE: every field starts from its held value, so no path through this block can infer a latch.
    st_d = st_q;
    if (wr_i && (sel_i == SEL_LEN)) begin
      st_d.len0 = wr_data_i[6:0];
      st_d.len1 = wr_data_i[14:8];
    end
    if (ctrl_wr) begin
      if (wr_data_i[WB_SET_FULL0]) st_d.full[0] = 1'b1;
      if (wr_data_i[WB_SET_FULL1]) st_d.full[1] = 1'b1;
      if (wr_data_i[WB_CLR_FULL0]) st_d.full[0] = 1'b0;
      if (wr_data_i[WB_CLR_FULL1]) st_d.full[1] = 1'b0;
      if (wr_data_i[WB_SET_STALL]) st_d.stall = 1'b1;
      if (wr_data_i[WB_CLR_STALL]) st_d.stall = 1'b0;
      if (wr_data_i[WB_LD_TOG])    st_d.toggle = wr_data_i[WB_TOG_VAL];
      if (wr_data_i[WB_LD_EN])     st_d.enable = wr_data_i[WB_EN_VAL];
`ifdef USB_EP_ARRAY_ISO_EN
      if (wr_data_i[WB_LD_ISO])    st_d.iso = wr_data_i[WB_ISO_VAL];
`endif
    end
    // A completed transaction owns the active bank, bank pointer and toggle.
    if (upd_i) begin
      st_d.full[st_q.bank] = ~IS_IN;
      if (!IS_IN) begin
        if (st_q.bank) st_d.len1 = len_i;
        else           st_d.len0 = len_i;
      end
      st_d.bank    = ~st_q.bank;
      st_d.toggle  = st_q.iso ? st_q.toggle : ~st_q.toggle;
      st_d.pending = 1'b1;
    end
    if (ctrl_wr && wr_data_i[WB_CLR_PEND]) st_d.pending = 1'b0;
    if (setup_i) begin
      st_d.toggle = 1'b1;
      st_d.stall  = 1'b0;
    end
    // Bus reset keeps the CPU's configuration and drops all transfer state.
    if (usb_rst) begin
      st_d        = '0;
      st_d.enable = st_q.enable;
      st_d.iso    = st_q.iso;
    end
  end

  // NOTE: state flops take non-blocking assignments so every channel samples the same pre-edge values.
  always_ff @(posedge clk_48 or posedge irst) begin
    if (irst) st_q <= '0;
    else      st_q <= st_d;
  end

  assign st_o = st_q;

endmodule

// File: rtl/usb_ep_array.sv
// USB endpoint controller: 2*NUM_EP channels, byte counter, handshake mux,
// packet-RAM addressing and CPU window. Optional iso via USB_EP_ARRAY_ISO_EN.
module usb_ep_array
  import usb_ep_pkg::*;
#(
  parameter int NUM_EP = 4,
  parameter int EPW    = 2
) (
  input  logic            clk_48,
  input  logic            irst,
  input  logic            usb_rst,
  input  logic            transaction_active,
  input  logic [3:0]      endpoint,
  input  logic            direction_in,
  input  logic            setup,
  input  logic            data_strobe,
  input  logic            success,
  output logic [1:0]      handshake,
  output logic            toggle,
  output logic            bank,
  output logic            in_data_valid,
  output logic [EPW+7:0]  ram_addr,
  output logic            ram_we,
  output logic [6:0]      cnt,
  input  logic [EPW+1:0]  ctrl_addr,
  input  logic            ctrl_wr_strobe,
  input  logic [15:0]     ctrl_wr_data,
  output logic [15:0]     ctrl_rd_data,
  output logic            irq
);

  localparam int NCH = 2 * NUM_EP;
  localparam int CW  = EPW + 1;

  chan_st_t        chan_st [NCH];
  logic [6:0]      cnt_q, cnt_d;
  logic            ep_valid, cpu_valid, sel_dir, sel_iso, cur_full, accept;
  logic [CW-1:0]   sel_idx, cpu_idx;
  hs_e             hs;

  assign ep_valid  = ({1'b0, endpoint} < 5'(NUM_EP));
  assign sel_dir   = direction_in && !setup;
  assign sel_idx   = {endpoint[EPW-1:0], sel_dir};
  assign cpu_idx   = ctrl_addr[EPW+1:1];
  assign cpu_valid = ({1'b0, ctrl_addr[EPW+1:2]} < (EPW+1)'(NUM_EP));
  assign cur_full  = ep_valid && chan_st[sel_idx].full[chan_st[sel_idx].bank];

`ifdef USB_EP_ARRAY_ISO_EN
  assign sel_iso = ep_valid && chan_st[sel_idx].iso;
`else
  assign sel_iso = 1'b0;
`endif

  always_comb begin
    cnt_d = cnt_q;
    if (!transaction_active || usb_rst)             cnt_d = '0;
    else if (data_strobe && (cnt_q < 7'(MAX_PKT)))  cnt_d = cnt_q + 7'd1;
  end

  always_ff @(posedge clk_48 or posedge irst) begin
    if (irst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  // SETUP to ep0 is always accepted so the host can recover a stalled pipe.
  always_comb begin
    hs = HS_STALL;
    if (!ep_valid || !chan_st[sel_idx].enable)    hs = HS_STALL;
    else if (setup && (endpoint == 4'd0))         hs = HS_ACK;
    else if (chan_st[sel_idx].stall && !setup)    hs = HS_STALL;
    else if (sel_iso)                             hs = HS_NONE;
    else if (!sel_dir)                            hs = cur_full ? HS_NAK : HS_ACK;
    else                                          hs = cur_full ? HS_ACK : HS_NAK;
  end

  assign accept        = (hs == HS_ACK) || (sel_iso && (hs == HS_NONE));
  assign handshake     = hs;
  assign toggle        = ep_valid && chan_st[sel_idx].toggle;
  assign bank          = ep_valid && chan_st[sel_idx].bank;
  assign in_data_valid = sel_dir && cur_full;
  assign cnt           = cnt_q;
  assign ram_addr      = {endpoint[EPW-1:0], sel_dir, bank, cnt_q[5:0]};
  assign ram_we        = data_strobe && !cnt_q[6] && !sel_dir && accept;

  for (genvar g = 0; g < NCH; g++) begin : g_chan
    localparam logic [CW-1:0] IDX = CW'(g);
    logic upd, stp, wr;
    assign upd = success && accept && (sel_idx == IDX);
    assign stp = success && accept && setup && (endpoint[EPW-1:0] == IDX[CW-1:1]);
    assign wr  = ctrl_wr_strobe && cpu_valid && (cpu_idx == IDX);
    usb_ep_chan #(.IS_IN((g % 2) != 0)) u_chan (
      .clk_48    (clk_48),
      .irst      (irst),
      .usb_rst   (usb_rst),
      .upd_i     (upd),
      .setup_i   (stp),
      .len_i     (cnt_q),
      .wr_i      (wr),
      .sel_i     (ctrl_addr[0]),
      .wr_data_i (ctrl_wr_data),
      .st_o      (chan_st[g])
    );
  end

  always_comb begin
    ctrl_rd_data = '0;
    if (cpu_valid) begin
      if (ctrl_addr[0] == SEL_LEN) begin
        ctrl_rd_data = {1'b0, chan_st[cpu_idx].len1, 1'b0, chan_st[cpu_idx].len0};
      end else begin
        ctrl_rd_data[RB_FULL0]   = chan_st[cpu_idx].full[0];
        ctrl_rd_data[RB_FULL1]   = chan_st[cpu_idx].full[1];
        ctrl_rd_data[RB_BANK]    = chan_st[cpu_idx].bank;
        ctrl_rd_data[RB_TOGGLE]  = chan_st[cpu_idx].toggle;
        ctrl_rd_data[RB_STALL]   = chan_st[cpu_idx].stall;
        ctrl_rd_data[RB_ENABLE]  = chan_st[cpu_idx].enable;
        ctrl_rd_data[RB_PENDING] = chan_st[cpu_idx].pending;
        ctrl_rd_data[RB_ISO]     = chan_st[cpu_idx].iso;
      end
    end
  end

  always_comb begin
    irq = 1'b0;
    for (int i = 0; i < NCH; i++) irq |= chan_st[i].pending && chan_st[i].enable;
  end

endmodule
